// File: rtl/inst_rom_arbiter_if.sv
// Requester-side bundle for one instruction ROM read port (CPU fetch or debug/loader).
interface inst_rom_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/inst_rom_arbiter.sv
// Two-port instruction ROM arbiter: combinational grant, registered issue and return stages.
// Round-robin or m0 fixed priority with an m1 starvation guard.
module inst_rom_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned FIXED_PRI = 0,
  parameter int unsigned MAX_WAIT  = 8
) (
  input  logic              clk,
  input  logic              rst,
  inst_rom_arbiter_if.slave m0,
  inst_rom_arbiter_if.slave m1,
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_data_i
);

  localparam int unsigned CntW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CntW-1:0] MaxWait = CntW'(MAX_WAIT);

  typedef enum logic {OwnM0, OwnM1} owner_e;

  logic              gnt0, gnt1;
  logic [CntW-1:0]   wait_q, wait_d;
  owner_e            last_q, last_d;
  owner_e            owner_q, owner_d;
  logic              rom_ce_q, rom_ce_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  // Grants are gated by reset so nothing is accepted while rst is low.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst) begin
      if (m0.req && m1.req) begin
        if (FIXED_PRI != 0) begin
          gnt1 = (wait_q == MaxWait);
        end else begin
          gnt1 = (last_q == OwnM0);
        end
        gnt0 = ~gnt1;
      end else begin
        gnt0 = m0.req;
        gnt1 = m1.req;
      end
    end
  end

  always_comb begin
    wait_d     = wait_q;
    last_d     = last_q;
    owner_d    = owner_q;
    rom_addr_d = rom_addr_q;
    rom_ce_d   = gnt0 | gnt1;

    if (!m1.req || gnt1) begin
      wait_d = '0;
    end else if (wait_q != MaxWait) begin
      wait_d = wait_q + CntW'(1);
    end

    if (gnt0) begin
      last_d     = OwnM0;
      owner_d    = OwnM0;
      rom_addr_d = m0.addr;
    end else if (gnt1) begin
      last_d     = OwnM1;
      owner_d    = OwnM1;
      rom_addr_d = m1.addr;
    end

    // ROM data is valid while rom_ce_o is high; route it to whoever issued that access.
    rvalid0_d = rom_ce_q && (owner_q == OwnM0);
    rvalid1_d = rom_ce_q && (owner_q == OwnM1);
    rdata0_d  = rvalid0_d ? rom_data_i : rdata0_q;
    rdata1_d  = rvalid1_d ? rom_data_i : rdata1_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_q     <= '0;
      last_q     <= OwnM1;
      owner_q    <= OwnM0;
      rom_ce_q   <= 1'b0;
      rom_addr_q <= '0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      wait_q     <= wait_d;
      last_q     <= last_d;
      owner_q    <= owner_d;
      rom_ce_q   <= rom_ce_d;
      rom_addr_q <= rom_addr_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  assign m0.gnt     = gnt0;
  assign m1.gnt     = gnt1;
  assign m0.rvalid  = rvalid0_q;
  assign m1.rvalid  = rvalid1_q;
  assign m0.rdata   = rdata0_q;
  assign m1.rdata   = rdata1_q;
  assign rom_ce_o   = rom_ce_q;
  assign rom_addr_o = rom_addr_q;

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// Bench for inst_rom_arbiter: a round-robin and a fixed-priority instance share one stimulus
// stream and are compared each cycle against a grant-log reference model.
module tb_inst_rom_arbiter;

  localparam int MaxWait = 8;
  localparam int VW      = 101;
  localparam int LogLen  = 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req = 1'b0, m1_req = 1'b0;
  logic [31:0] m0_addr = '0, m1_addr = '0;

  always #5 clk = ~clk;

  inst_rom_arbiter_if rr_m0 ();
  inst_rom_arbiter_if rr_m1 ();
  inst_rom_arbiter_if fp_m0 ();
  inst_rom_arbiter_if fp_m1 ();

  assign rr_m0.req = m0_req;
  assign rr_m0.addr = m0_addr;
  assign rr_m1.req = m1_req;
  assign rr_m1.addr = m1_addr;
  assign fp_m0.req = m0_req;
  assign fp_m0.addr = m0_addr;
  assign fp_m1.req = m1_req;
  assign fp_m1.addr = m1_addr;

  logic        rr_ce, fp_ce;
  logic [31:0] rr_addr, fp_addr, rr_data, fp_data;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a == 32'h4) return 32'h3401_1100;
    return {a[15:0], ~a[15:0]} ^ 32'h5A3C_0F69;
  endfunction

  assign rr_data = rom_word(rr_addr);
  assign fp_data = rom_word(fp_addr);

  inst_rom_arbiter #(.FIXED_PRI(0), .MAX_WAIT(MaxWait)) u_rr (
    .clk        (clk),
    .rst        (rst_n),
    .m0         (rr_m0),
    .m1         (rr_m1),
    .rom_ce_o   (rr_ce),
    .rom_addr_o (rr_addr),
    .rom_data_i (rr_data)
  );

  inst_rom_arbiter #(.FIXED_PRI(1), .MAX_WAIT(MaxWait)) u_fp (
    .clk        (clk),
    .rst        (rst_n),
    .m0         (fp_m0),
    .m1         (fp_m1),
    .rom_ce_o   (fp_ce),
    .rom_addr_o (fp_addr),
    .rom_data_i (fp_data)
  );

  // Reference model: per-mode log of which port was granted in each cycle (-1 = none).
  int           g_port  [2][LogLen];
  logic [31:0]  g_addr  [2][LogLen];
  bit           last_m1 [2];
  int           wait_cnt[2];
  logic [31:0]  addr_m  [2];
  logic [31:0]  rd_m    [2][2];
  logic [VW-1:0] exp_v  [2];
  logic [VW-1:0] obs_v  [2];
  int           cyc = 2;
  int           checks = 0;
  int           passed = 0;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      last_m1[k]  = 1'b1;
      wait_cnt[k] = 0;
      addr_m[k]   = '0;
      rd_m[k][0]  = '0;
      rd_m[k][1]  = '0;
    end
  endtask

  // Drive one cycle of stimulus, then at the falling edge build expected and observed vectors.
  task automatic cycle(input bit r0, input logic [31:0] a0, input bit r1,
                       input logic [31:0] a1, input bit rv);
    int p;
    @(posedge clk);
    #1;
    rst_n   = rv;
    m0_req  = r0;
    m0_addr = a0;
    m1_req  = r1;
    m1_addr = a1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!rv) begin
        g_port[k][cyc-1] = -1;
        g_port[k][cyc]   = -1;
        exp_v[k]         = '0;
      end else begin
        if (r0 && r1) begin
          if (k == 0) p = last_m1[k] ? 0 : 1;
          else        p = (wait_cnt[k] == MaxWait) ? 1 : 0;
        end else if (r0) p = 0;
        else if (r1)     p = 1;
        else             p = -1;
        if (g_port[k][cyc-2] != -1) rd_m[k][g_port[k][cyc-2]] = rom_word(g_addr[k][cyc-2]);
        exp_v[k] = {p == 0, p == 1, g_port[k][cyc-1] != -1, addr_m[k],
                    g_port[k][cyc-2] == 0, g_port[k][cyc-2] == 1, rd_m[k][0], rd_m[k][1]};
        g_port[k][cyc] = p;
        g_addr[k][cyc] = (p == 1) ? a1 : a0;
        if (p != -1) begin
          addr_m[k]  = g_addr[k][cyc];
          last_m1[k] = (p == 1);
        end
        if (!r1 || p == 1)          wait_cnt[k] = 0;
        else if (wait_cnt[k] < MaxWait) wait_cnt[k] = wait_cnt[k] + 1;
      end
    end
    if (!rv) model_reset();
    obs_v[0] = {rr_m0.gnt, rr_m1.gnt, rr_ce, rr_addr, rr_m0.rvalid, rr_m1.rvalid,
                rr_m0.rdata, rr_m1.rdata};
    obs_v[1] = {fp_m0.gnt, fp_m1.gnt, fp_ce, fp_addr, fp_m0.rvalid, fp_m1.rvalid,
                fp_m0.rdata, fp_m1.rdata};
    cyc++;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), $urandom, 1'b0);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_v[k] !== exp_v[k])
          $display("FAIL reset k=%0d cyc=%0d got=%h want=%h", k, cyc, obs_v[k], exp_v[k]);
        else passed++;
      end
    end
    cycle(1'b0, '0, 1'b0, '0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs_v[k] !== exp_v[k])
        $display("FAIL reset_release k=%0d got=%h want=%h", k, obs_v[k], exp_v[k]);
      else passed++;
    end
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 32'h10, 1'b1, 32'h20, 1'b1);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_v[k] !== exp_v[k])
          $display("FAIL round_robin k=%0d cyc=%0d got=%h want=%h", k, cyc, obs_v[k], exp_v[k]);
        else passed++;
      end
      checks++;
      if (rr_m0.gnt !== ((i % 2) == 0))
        $display("FAIL rr_grant_alternate i=%0d got=%b want=%b", i, rr_m0.gnt, (i % 2) == 0);
      else passed++;
      if (i >= 1) begin
        checks++;
        if (rr_addr !== (((i % 2) == 1) ? 32'h10 : 32'h20))
          $display("FAIL rr_rom_addr i=%0d got=%h", i, rr_addr);
        else passed++;
      end
    end
  endtask

  task automatic test_fixed_priority();
    cycle(1'b0, '0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 18; i++) begin
      cycle(1'b1, 32'h100 + 32'(i * 4), 1'b1, 32'h800, 1'b1);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_v[k] !== exp_v[k])
          $display("FAIL fixed_priority k=%0d cyc=%0d got=%h want=%h", k, cyc, obs_v[k],
                   exp_v[k]);
        else passed++;
      end
      checks++;
      if (fp_m1.gnt !== (i == 8 || i == 17))
        $display("FAIL fp_starvation_guard i=%0d got=%b want=%b", i, fp_m1.gnt,
                 (i == 8 || i == 17));
      else passed++;
    end
  endtask

  task automatic test_single();
    cycle(1'b0, '0, 1'b0, '0, 1'b1);
    cycle(1'b1, 32'h4, 1'b0, 32'h44, 1'b1);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) cycle(1'b0, '0, 1'b0, '0, 1'b1);
      else       cycle(1'b0, '0, 1'b0, '0, 1'b1);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_v[k] !== exp_v[k])
          $display("FAIL single k=%0d cyc=%0d got=%h want=%h", k, cyc, obs_v[k], exp_v[k]);
        else passed++;
      end
      if (i == 1) begin
        checks++;
        if (fp_m0.rvalid !== 1'b1 || fp_m0.rdata !== 32'h3401_1100)
          $display("FAIL single_rdata got=%b/%h want=1/34011100", fp_m0.rvalid, fp_m0.rdata);
        else passed++;
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      cycle(i < 3, 32'(i * 4), 1'b0, '0, 1'b1);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_v[k] !== exp_v[k])
          $display("FAIL back_to_back k=%0d cyc=%0d got=%h want=%h", k, cyc, obs_v[k],
                   exp_v[k]);
        else passed++;
      end
      if (i >= 2 && i <= 4) begin
        checks++;
        if (rr_m0.rvalid !== 1'b1 || rr_m0.rdata !== rom_word(32'((i - 2) * 4)))
          $display("FAIL b2b_return i=%0d got=%b/%h", i, rr_m0.rvalid, rr_m0.rdata);
        else passed++;
      end
    end
  endtask

  task automatic test_drop();
    cycle(1'b0, '0, 1'b0, '0, 1'b1);
    cycle(1'b1, 32'h300, 1'b1, 32'h200, 1'b1);
    for (int i = 0; i < 13; i++) begin
      if (i == 0)     cycle(1'b1, 32'h304, 1'b0, '0, 1'b1);
      else if (i < 4) cycle(1'b0, '0, 1'b0, '0, 1'b1);
      else            cycle(1'b1, 32'h400, 1'b1, 32'h500, 1'b1);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_v[k] !== exp_v[k])
          $display("FAIL drop k=%0d cyc=%0d got=%h want=%h", k, cyc, obs_v[k], exp_v[k]);
        else passed++;
      end
      checks++;
      if (fp_addr === 32'h200 || fp_m1.gnt !== (i == 12))
        $display("FAIL drop_no_m1 i=%0d addr=%h gnt=%b", i, fp_addr, fp_m1.gnt);
      else passed++;
    end
  endtask

  task automatic test_reset_inflight();
    cycle(1'b0, '0, 1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1, 32'h40, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, '0, 1'b0, '0, i >= 2);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_v[k] !== exp_v[k])
          $display("FAIL reset_inflight k=%0d cyc=%0d got=%h want=%h", k, cyc, obs_v[k],
                   exp_v[k]);
        else passed++;
      end
      checks++;
      if (rr_m1.rvalid !== 1'b0 || fp_m1.rvalid !== 1'b0 || fp_ce !== 1'b0)
        $display("FAIL reset_inflight_rvalid i=%0d got=%b%b%b want=000", i, rr_m1.rvalid,
                 fp_m1.rvalid, fp_ce);
      else passed++;
    end
  endtask

  task automatic test_random();
    bit          r0 = 1'b0, r1 = 1'b0, rv;
    logic [31:0] a0 = '0, a1 = '0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        r0 = 1'($urandom_range(0, 1));
        a0 = $urandom & 32'h0000_FFFC;
      end
      if ($urandom_range(0, 2) == 0) begin
        r1 = 1'($urandom_range(0, 1));
        a1 = $urandom & 32'h0000_FFFC;
      end
      rv = ($urandom_range(0, 49) != 0);
      cycle(r0, a0, r1, a1, rv);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_v[k] !== exp_v[k])
          $display("FAIL random k=%0d cyc=%0d got=%h want=%h", k, cyc, obs_v[k], exp_v[k]);
        else passed++;
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < LogLen; i++) begin
        g_port[k][i] = -1;
        g_addr[k][i] = '0;
      end
    model_reset();
    test_reset();
    test_round_robin();
    test_fixed_priority();
    test_single();
    test_back_to_back();
    test_drop();
    test_reset_inflight();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
